// File: rtl/wdm_pkg.sv
// Shared definitions for the write-data manager: default widths and FSM state encodings.
package wdm_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int SKID_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } wdm_state_e;

endpackage

// File: rtl/wdm_skid.sv
// Small circular skid buffer with a combinational head. A push to a full buffer is
// ignored unless a pop happens in the same cycle, which frees the slot.
module wdm_skid import wdm_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = SKID_DEPTH_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on natural overflow.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wdm.sv
// Write-data manager: forwards an upstream byte stream into a FIFO write port, parking
// bytes in a skid buffer while the FIFO is throttled and counting any that overflow it.
module wdm import wdm_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] iv_data,
  input  logic              i_data_wr,
  output logic              o_data_rdy,
  input  logic              i_fifo_full,
  input  logic              i_fifo_af,
  output logic              o_fifo_wr,
  output logic [DATA_W-1:0] ov_fifo_data,
  output logic [CNT_W-1:0]  ov_drop_cnt,
  output logic              o_overflow,
  output logic [1:0]        o_state
);

  localparam int CW = $clog2(SKID_DEPTH+1);

  // Upstream handshake: i_data_wr marks iv_data valid for exactly one cycle and is never
  // stalled; o_data_rdy is only advisory, and a byte offered with no skid room is dropped.

  wdm_state_e        state;
  logic              ok;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic [CW-1:0]     next_count;
  logic              skid_full;
  logic              skid_empty;

  assign ok      = !i_fifo_af && !i_fifo_full;
  assign o_state = state;

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_PASS:  push = i_data_wr && !ok;
      ST_HOLD,
      ST_DRAIN: begin
        push = i_data_wr;
        pop  = ok && !skid_empty;
      end
      default: ;
    endcase
    // A pop in the same cycle frees the slot, so only an unmatched push to a full skid drops.
    drop       = push && skid_full && !pop;
    next_count = count + CW'(push && !drop) - CW'(pop);
  end

  wdm_skid #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (pop),
    .din     (iv_data),
    .dout    (head),
    .count   (count),
    .full    (skid_full),
    .empty   (skid_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_PASS;
      o_fifo_wr    <= 1'b0;
      ov_fifo_data <= '0;
      o_data_rdy   <= 1'b0;
      ov_drop_cnt  <= '0;
      o_overflow   <= 1'b0;
    end else begin
      o_fifo_wr  <= 1'b0;
      o_data_rdy <= (next_count <= CW'(SKID_DEPTH - 2));
      if (drop) begin
        o_overflow <= 1'b1;
        if (ov_drop_cnt != {CNT_W{1'b1}}) ov_drop_cnt <= ov_drop_cnt + CNT_W'(1);
      end
      case (state)
        ST_PASS: begin
          if (i_data_wr) begin
            if (ok) begin
              o_fifo_wr    <= 1'b1;
              ov_fifo_data <= iv_data;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        // HOLD and DRAIN share datapath behaviour; HOLD records that the last cycle was throttled.
        ST_HOLD,
        ST_DRAIN: begin
          if (ok) begin
            if (pop) begin
              o_fifo_wr    <= 1'b1;
              ov_fifo_data <= head;
            end
            state <= (next_count == '0) ? ST_PASS : ST_DRAIN;
          end else begin
            state <= ST_HOLD;
          end
        end
        default: state <= ST_PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_wdm.sv
// Directed bench for wdm: a per-cycle vector table on the default build, plus a
// hand-written saturation/reset sequence on a CNT_W=4 build.
module tb_wdm;
  import wdm_pkg::*;

  logic        clk;
  logic        rst_n, wr, af, full;
  logic [7:0]  din;
  logic        rdy, fwr, ovf;
  logic [7:0]  fdata;
  logic [15:0] drop;
  logic [1:0]  st;

  logic        s_rst_n, s_wr, s_af, s_full;
  logic [7:0]  s_din;
  logic        s_rdy, s_fwr, s_ovf;
  logic [7:0]  s_fdata;
  logic [3:0]  s_drop;
  logic [1:0]  s_st;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        rst_n;
    logic        wr;
    logic [7:0]  din;
    logic        af;
    logic        full;
    logic        e_wr;
    logic [7:0]  e_data;
    logic        e_rdy;
    logic [15:0] e_drop;
    logic        e_ovf;
    logic [1:0]  e_state;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  wdm u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .iv_data      (din),
    .i_data_wr    (wr),
    .o_data_rdy   (rdy),
    .i_fifo_full  (full),
    .i_fifo_af    (af),
    .o_fifo_wr    (fwr),
    .ov_fifo_data (fdata),
    .ov_drop_cnt  (drop),
    .o_overflow   (ovf),
    .o_state      (st)
  );

  wdm #(.CNT_W(4)) u_dut4 (
    .i_clk        (clk),
    .i_rst_n      (s_rst_n),
    .iv_data      (s_din),
    .i_data_wr    (s_wr),
    .o_data_rdy   (s_rdy),
    .i_fifo_full  (s_full),
    .i_fifo_af    (s_af),
    .o_fifo_wr    (s_fwr),
    .ov_fifo_data (s_fdata),
    .ov_drop_cnt  (s_drop),
    .o_overflow   (s_ovf),
    .o_state      (s_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  function automatic void a(input logic r, input logic w, input logic [7:0] d, input logic f_af,
                            input logic f_full, input logic ewr, input logic [7:0] ed,
                            input logic erdy, input logic [15:0] edrop, input logic eovf,
                            input logic [1:0] est);
    vec_t v;
    v.rst_n = r;   v.wr = w;       v.din = d;      v.af = f_af;    v.full = f_full;
    v.e_wr = ewr;  v.e_data = ed;  v.e_rdy = erdy; v.e_drop = edrop;
    v.e_ovf = eovf; v.e_state = est;
    vecs.push_back(v);
    if (ewr) exp_q.push_back(ed);
  endfunction

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; wr = vecs[i].wr; din = vecs[i].din;
      af = vecs[i].af; full = vecs[i].full;
      @(posedge clk); #1;
      check("fifo_wr",  i, 32'(fwr),  32'(vecs[i].e_wr));
      check("data_rdy", i, 32'(rdy),  32'(vecs[i].e_rdy));
      check("drop_cnt", i, 32'(drop), 32'(vecs[i].e_drop));
      check("overflow", i, 32'(ovf),  32'(vecs[i].e_ovf));
      check("state",    i, 32'(st),   32'(vecs[i].e_state));
      if (vecs[i].e_wr || !vecs[i].rst_n)
        check("fifo_data", i, 32'(fdata), 32'(vecs[i].e_data));
      if (fwr) begin
        if (exp_q.size() == 0) check("sb_extra_write", i, 32'(fdata), 32'hFFFF_FFFF);
        else                   check("sb_order", i, 32'(fdata), 32'(exp_q.pop_front()));
      end
    end
    check("sb_left", 0, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; wr = 1'b0; din = '0; af = 1'b0; full = 1'b0;
    s_rst_n = 1'b0; s_wr = 1'b0; s_din = '0; s_af = 1'b0; s_full = 1'b0;

    // reset held with writes offered, then release
    repeat (3) a(0, 1, 8'h55, 0, 0, 0, 8'h00, 0, 0, 0, ST_PASS);
    a(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, ST_PASS);
    // pass-through 0x01..0x10
    for (int i = 1; i <= 16; i++) a(1, 1, 8'(i), 0, 0, 1, 8'(i), 1, 0, 0, ST_PASS);
    a(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, ST_PASS);
    a(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0, ST_PASS);
    // throttle and drain, then new input
    a(1, 1, 8'h21, 1, 0, 0, 8'h00, 1, 0, 0, ST_HOLD);
    a(1, 1, 8'h22, 1, 0, 0, 8'h00, 1, 0, 0, ST_HOLD);
    a(1, 1, 8'h23, 1, 0, 0, 8'h00, 0, 0, 0, ST_HOLD);
    a(1, 0, 8'h00, 0, 0, 1, 8'h21, 1, 0, 0, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'h22, 1, 0, 0, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'h23, 1, 0, 0, ST_PASS);
    a(1, 1, 8'h24, 0, 0, 1, 8'h24, 1, 0, 0, ST_PASS);
    a(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, ST_PASS);
    // overflow: 4 buffered, 3 dropped
    a(1, 1, 8'hA0, 1, 0, 0, 8'h00, 1, 0, 0, ST_HOLD);
    a(1, 1, 8'hA1, 1, 0, 0, 8'h00, 1, 0, 0, ST_HOLD);
    a(1, 1, 8'hA2, 1, 0, 0, 8'h00, 0, 0, 0, ST_HOLD);
    a(1, 1, 8'hA3, 1, 0, 0, 8'h00, 0, 0, 0, ST_HOLD);
    a(1, 1, 8'hA4, 1, 0, 0, 8'h00, 0, 1, 1, ST_HOLD);
    a(1, 1, 8'hA5, 1, 0, 0, 8'h00, 0, 2, 1, ST_HOLD);
    a(1, 1, 8'hA6, 1, 0, 0, 8'h00, 0, 3, 1, ST_HOLD);
    a(1, 0, 8'h00, 0, 0, 1, 8'hA0, 0, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hA1, 1, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hA2, 1, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hA3, 1, 3, 1, ST_PASS);
    a(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 3, 1, ST_PASS);
    // drain with concurrent input: occupancy stays 3
    a(1, 1, 8'hB0, 1, 0, 0, 8'h00, 1, 3, 1, ST_HOLD);
    a(1, 1, 8'hB1, 1, 0, 0, 8'h00, 1, 3, 1, ST_HOLD);
    a(1, 1, 8'hB2, 1, 0, 0, 8'h00, 0, 3, 1, ST_HOLD);
    a(1, 1, 8'hB3, 0, 0, 1, 8'hB0, 0, 3, 1, ST_DRAIN);
    a(1, 1, 8'hB4, 0, 0, 1, 8'hB1, 0, 3, 1, ST_DRAIN);
    a(1, 1, 8'hB5, 0, 0, 1, 8'hB2, 0, 3, 1, ST_DRAIN);
    a(1, 1, 8'hB6, 0, 0, 1, 8'hB3, 0, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hB4, 1, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hB5, 1, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hB6, 1, 3, 1, ST_PASS);
    // throttle toggling each cycle (af, then full) with streaming input
    a(1, 1, 8'hC0, 1, 0, 0, 8'h00, 1, 3, 1, ST_HOLD);
    a(1, 1, 8'hC1, 0, 0, 1, 8'hC0, 1, 3, 1, ST_DRAIN);
    a(1, 1, 8'hC2, 1, 0, 0, 8'h00, 1, 3, 1, ST_HOLD);
    a(1, 1, 8'hC3, 0, 0, 1, 8'hC1, 1, 3, 1, ST_DRAIN);
    a(1, 1, 8'hC4, 0, 1, 0, 8'h00, 0, 3, 1, ST_HOLD);
    a(1, 1, 8'hC5, 0, 0, 1, 8'hC2, 0, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hC3, 1, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hC4, 1, 3, 1, ST_DRAIN);
    a(1, 0, 8'h00, 0, 0, 1, 8'hC5, 1, 3, 1, ST_PASS);
    // 24 bytes while throttled: 4 buffered, 20 more drops
    for (int i = 0; i < 24; i++) begin
      cnt = (i + 1 < 4) ? i + 1 : 4;
      a(1, 1, 8'(8'hD0 + i), 1, 0, 0, 8'h00, (cnt <= 2), 16'(3 + ((i >= 4) ? i - 3 : 0)), 1, ST_HOLD);
    end
    // reset mid-HOLD with FIFO open: nothing stale may be written afterwards
    a(0, 1, 8'hEE, 0, 0, 0, 8'h00, 0, 0, 0, ST_PASS);
    a(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, ST_PASS);
    a(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, ST_PASS);
    a(1, 1, 8'hE0, 0, 0, 1, 8'hE0, 1, 0, 0, ST_PASS);
    a(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, ST_PASS);

    run_table();

    // CNT_W=4 build: saturation, then mid-HOLD reset
    repeat (2) @(posedge clk);
    #1;
    check("s_rst_drop", 0, 32'(s_drop), 0);
    check("s_rst_rdy",  0, 32'(s_rdy),  0);
    s_rst_n = 1'b1; s_af = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s_wr = 1'b1; s_din = 8'(i);
      @(posedge clk); #1;
      if (i == 10) check("s_drop_mid", i, 32'(s_drop), 7);
      if (i == 18) check("s_drop_sat", i, 32'(s_drop), 15);
      check("s_no_write", i, 32'(s_fwr), 0);
    end
    check("s_drop_end", 0, 32'(s_drop), 32'hF);
    check("s_ovf",      0, 32'(s_ovf),  1);
    check("s_state",    0, 32'(s_st),   32'(ST_HOLD));
    s_rst_n = 1'b0; s_wr = 1'b1; s_af = 1'b0;
    @(posedge clk); #1;
    check("s_rst2_drop", 0, 32'(s_drop), 0);
    check("s_rst2_ovf",  0, 32'(s_ovf),  0);
    check("s_rst2_wr",   0, 32'(s_fwr),  0);
    s_rst_n = 1'b1; s_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("s_post_wr",    i, 32'(s_fwr), 0);
      check("s_post_state", i, 32'(s_st),  32'(ST_PASS));
      check("s_post_rdy",   i, 32'(s_rdy), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
